// File: rtl/wbsdram_pkg.sv
// wbsdram_pkg: shared types for the two-master SDRAM Wishbone arbiter.
package wbsdram_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT0   = 3'd1,
    GNT1   = 3'd2,
    DRAIN0 = 3'd3,
    DRAIN1 = 3'd4
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/wbsdram_arbiter_if.sv
// wbsdram_arbiter_if: one Wishbone B4 pipelined link; master drives
// the request side, slave drives ack/stall/read data.
interface wbsdram_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 16
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   wdat;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   rdat;
  logic            ack;
  logic            stall;

  modport master (
    output cyc, stb, we, adr, wdat, sel,
    input  rdat, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, wdat, sel,
    output rdat, ack, stall
  );
endinterface

// File: rtl/wbsdram_arb_cnt.sv
// wbsdram_arb_cnt: saturating count of requests accepted by the slave
// but not yet acknowledged.
module wbsdram_arb_cnt #(
  parameter int MAX_OUT = 4,
  parameter int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o
);
  logic [OW-1:0] cnt_q, cnt_d;
  logic          up, dn;

  assign full_o = (cnt_q == OW'(MAX_OUT));
  assign zero_o = (cnt_q == '0);
  assign up     = inc_i & ~full_o;
  assign dn     = dec_i & ~zero_o;

  always_comb begin
    cnt_d = cnt_q;
    if (up && !dn)
      cnt_d = cnt_q + OW'(1);
    else if (dn && !up)
      cnt_d = cnt_q - OW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wbsdram_arbiter.sv
// wbsdram_arbiter: two-master Wishbone B4 pipelined arbiter in front
// of the SDRAM controller; grant is held until all acks return.
module wbsdram_arbiter
  import wbsdram_pkg::*;
#(
  parameter int AW        = 24,
  parameter int DW        = 16,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  wbsdram_arbiter_if.slave  m0,
  wbsdram_arbiter_if.slave  m1,
  wbsdram_arbiter_if.master s,
  output logic [1:0]        gnt_o
);
  localparam int SW = DW / 8;

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_GNT0   = GNT0;
  localparam logic [2:0] S_GNT1   = GNT1;
  localparam logic [2:0] S_DRAIN0 = DRAIN0;
  localparam logic [2:0] S_DRAIN1 = DRAIN1;

  logic [2:0] state_q, state_d;
  logic       last_q, last_d;
  logic       g0, g1, d0, d1;
  logic       full, zero, inc, dec;
  logic       sel1;

  logic [AW-1:0] adr_mux;
  logic [DW-1:0] dat_mux;
  logic [SW-1:0] sel_mux;

  wbsdram_arb_cnt #(
    .MAX_OUT (MAX_OUT)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (inc),
    .dec_i  (dec),
    .full_o (full),
    .zero_o (zero)
  );

  assign g0 = (state_q == S_GNT0);
  assign g1 = (state_q == S_GNT1);
  assign d0 = (state_q == S_DRAIN0);
  assign d1 = (state_q == S_DRAIN1);

  assign gnt_o = {g1 | d1, g0 | d0};
  assign sel1  = gnt_o[1];

  // stb is gated by the registered count only, never by s.stall
  assign s.cyc = |gnt_o;
  assign s.stb = (g0 & m0.cyc & m0.stb & ~full)
               | (g1 & m1.cyc & m1.stb & ~full);

  assign adr_mux = sel1 ? m1.adr  : m0.adr;
  assign dat_mux = sel1 ? m1.wdat : m0.wdat;
  assign sel_mux = sel1 ? m1.sel  : m0.sel;
  assign s.we    = sel1 ? m1.we   : m0.we;
  assign s.adr   = adr_mux;
  assign s.wdat  = dat_mux;
  assign s.sel   = sel_mux;

  assign inc = s.stb & ~s.stall;
  assign dec = s.ack & ~zero;

  assign m0.ack   = g0 & dec;
  assign m1.ack   = g1 & dec;
  assign m0.stall = ~g0 | s.stall | full;
  assign m1.stall = ~g1 | s.stall | full;
  assign m0.rdat  = s.rdat;
  assign m1.rdat  = s.rdat;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0.cyc && m1.cyc)
          state_d = (PRIO_MODE == PRIO_FIXED || last_q) ? S_GNT0 : S_GNT1;
        else if (m0.cyc)
          state_d = S_GNT0;
        else if (m1.cyc)
          state_d = S_GNT1;
      end
      S_GNT0, S_DRAIN0: begin
        if (!m0.cyc || state_q == S_DRAIN0) begin
          if (zero) begin
            state_d = m1.cyc ? S_GNT1 : S_IDLE;
            last_d  = 1'b0;
          end else begin
            state_d = S_DRAIN0;
          end
        end
      end
      S_GNT1, S_DRAIN1: begin
        if (!m1.cyc || state_q == S_DRAIN1) begin
          if (zero) begin
            state_d = m0.cyc ? S_GNT0 : S_IDLE;
            last_d  = 1'b1;
          end else begin
            state_d = S_DRAIN1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_wbsdram_arbiter.sv
// tb_wbsdram_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbitration rules.
module tb_wbsdram_arbiter;
  localparam int AW      = 24;
  localparam int DW      = 16;
  localparam int SW      = DW / 8;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    mcyc, mstb, mwe;
  logic [AW-1:0] madr [2];
  logic [DW-1:0] mdat [2];
  logic [SW-1:0] msel [2];
  logic          s_ack, s_stall;
  logic [DW-1:0] s_rdat;
  logic [1:0]    gnt_a, gnt_b;
  int            n_chk = 0;
  int            n_fail = 0;

  wbsdram_arbiter_if #(.AW(AW), .DW(DW)) m0a (), m1a (), sa ();
  wbsdram_arbiter_if #(.AW(AW), .DW(DW)) m0b (), m1b (), sb ();

  assign {m0a.cyc, m0a.stb, m0a.we} = {mcyc[0], mstb[0], mwe[0]};
  assign {m1a.cyc, m1a.stb, m1a.we} = {mcyc[1], mstb[1], mwe[1]};
  assign {m0b.cyc, m0b.stb, m0b.we} = {mcyc[0], mstb[0], mwe[0]};
  assign {m1b.cyc, m1b.stb, m1b.we} = {mcyc[1], mstb[1], mwe[1]};
  assign {m0a.adr, m0a.wdat, m0a.sel} = {madr[0], mdat[0], msel[0]};
  assign {m1a.adr, m1a.wdat, m1a.sel} = {madr[1], mdat[1], msel[1]};
  assign {m0b.adr, m0b.wdat, m0b.sel} = {madr[0], mdat[0], msel[0]};
  assign {m1b.adr, m1b.wdat, m1b.sel} = {madr[1], mdat[1], msel[1]};
  assign {sa.ack, sa.stall, sa.rdat} = {s_ack, s_stall, s_rdat};
  assign {sb.ack, sb.stall, sb.rdat} = {s_ack, s_stall, s_rdat};

  wbsdram_arbiter #(
    .AW(AW), .DW(DW), .PRIO_MODE(0), .MAX_OUT(MAX_OUT)
  ) u_rr (
    .clk(clk), .rst(rst), .m0(m0a.slave), .m1(m1a.slave),
    .s(sa.master), .gnt_o(gnt_a)
  );

  wbsdram_arbiter #(
    .AW(AW), .DW(DW), .PRIO_MODE(1), .MAX_OUT(MAX_OUT)
  ) u_fx (
    .clk(clk), .rst(rst), .m0(m0b.slave), .m1(m1b.slave),
    .s(sb.master), .gnt_o(gnt_b)
  );

  task automatic clear_inputs();
    mcyc = '0; mstb = '0; mwe = '0;
    for (int m = 0; m < 2; m++) begin
      madr[m] = '0; mdat[m] = '0; msel[m] = '0;
    end
    s_ack = 1'b0; s_stall = 1'b0; s_rdat = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    mcyc = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (gnt_a !== 2'b00 || gnt_b !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b/%b want 00", gnt_a, gnt_b);
    end
    n_chk++;
    if (sa.cyc !== 1'b0 || sa.stb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: cyc=%b stb=%b want 0/0", sa.cyc, sa.stb);
    end
    n_chk++;
    if ({m0a.ack, m1a.ack, m0a.stall, m1a.stall} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_ack_stall: got %b want 0011",
               {m0a.ack, m1a.ack, m0a.stall, m1a.stall});
    end
    rst = 1'b0;
    mcyc = 2'b00;
  endtask

  task automatic test_single_burst();
    int idx, nack;
    logic pend;
    do_reset();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b1; msel[0] = 2'b11;
    madr[0] = 24'h10; mdat[0] = 16'hA0A1;
    #1;
    n_chk++;
    if (gnt_a !== 2'b00 || sa.stb !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_latency: gnt=%b stb=%b want 00/0", gnt_a, sa.stb);
    end
    idx = 0; nack = 0; pend = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      s_ack = pend;
      pend = 1'b0;
      mstb[0] = (idx < 3);
      madr[0] = 24'h10 + AW'(idx);
      mdat[0] = 16'hA0A1 + DW'(idx);
      #1;
      if (c == 0) begin
        n_chk++;
        if (gnt_a !== 2'b01) begin
          n_fail++;
          $display("FAIL burst_gnt: got %b want 01", gnt_a);
        end
      end
      if (sa.stb && !s_stall) begin
        n_chk++;
        if (sa.adr !== 24'h10 + AW'(idx) || sa.wdat !== 16'hA0A1 + DW'(idx)
            || sa.we !== 1'b1) begin
          n_fail++;
          $display("FAIL burst_beat%0d: adr=%h dat=%h want %h %h", idx,
                   sa.adr, sa.wdat, 24'h10 + AW'(idx), 16'hA0A1 + DW'(idx));
        end
        idx++;
        pend = 1'b1;
      end
      if (m0a.ack) nack++;
    end
    n_chk++;
    if (idx != 3 || nack != 3) begin
      n_fail++;
      $display("FAIL burst_count: stb=%0d ack=%0d want 3 3", idx, nack);
    end
    @(negedge clk);
    s_ack = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (gnt_a !== 2'b00 || sa.cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_idle: gnt=%b cyc=%b want 00/0", gnt_a, sa.cyc);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    mcyc = 2'b11;
    @(negedge clk); #1;
    n_chk++;
    if (gnt_a !== 2'b01 || gnt_b !== 2'b01) begin
      n_fail++;
      $display("FAIL arb_first: rr=%b fx=%b want 01/01", gnt_a, gnt_b);
    end
    mcyc = 2'b00;
    @(negedge clk); #1;
    n_chk++;
    if (gnt_a !== 2'b00 || gnt_b !== 2'b00) begin
      n_fail++;
      $display("FAIL arb_release: rr=%b fx=%b want 00/00", gnt_a, gnt_b);
    end
    mcyc = 2'b11;
    @(negedge clk); #1;
    n_chk++;
    if (gnt_a !== 2'b10 || gnt_b !== 2'b01) begin
      n_fail++;
      $display("FAIL arb_second: rr=%b fx=%b want 10/01", gnt_a, gnt_b);
    end
    mcyc[0] = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (gnt_a !== 2'b10 || gnt_b !== 2'b10) begin
      n_fail++;
      $display("FAIL arb_handover: rr=%b fx=%b want 10/10", gnt_a, gnt_b);
    end
    mcyc = 2'b00;
  endtask

  task automatic test_max_out();
    int issued, pend, nack;
    do_reset();
    mcyc[0] = 1'b1; mwe[0] = 1'b0; msel[0] = 2'b11;
    issued = 0; pend = 0; nack = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      s_ack = (c >= 10) && (pend > 0);
      s_rdat = 16'h3000 + DW'(c);
      mstb[0] = (issued < 6);
      madr[0] = 24'h200 + AW'(issued);
      #1;
      if (c >= 4 && c <= 10) begin
        n_chk++;
        if (m0a.stall !== 1'b1) begin
          n_fail++;
          $display("FAIL maxout_stall c%0d: got %b want 1", c, m0a.stall);
        end
      end
      if (c == 10) begin
        n_chk++;
        if (issued != 4) begin
          n_fail++;
          $display("FAIL maxout_limit: got %0d want 4", issued);
        end
      end
      if (sa.stb && !s_stall) begin
        issued++;
        pend++;
      end
      if (s_ack) pend--;
      if (m0a.ack) nack++;
    end
    n_chk++;
    if (issued != 6 || nack != 6) begin
      n_fail++;
      $display("FAIL maxout_total: stb=%0d ack=%0d want 6 6", issued, nack);
    end
    @(negedge clk);
    s_ack = 1'b0; mcyc = 2'b00; mstb = 2'b00;
  endtask

  task automatic test_drain();
    int issued;
    do_reset();
    mcyc = 2'b11;
    mwe[0] = 1'b0; madr[0] = 24'h300;
    mstb[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 24'h400; mdat[1] = 16'hBEEF;
    issued = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mstb[0] = (issued < 2);
      #1;
      if (sa.stb && !s_stall) issued++;
    end
    @(negedge clk);
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (issued != 2 || gnt_a !== 2'b01 || sa.cyc !== 1'b1 || sa.stb !== 1'b0
        || m0a.stall !== 1'b1 || m1a.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_enter: n=%0d gnt=%b cyc=%b stb=%b st=%b%b", issued,
               gnt_a, sa.cyc, sa.stb, m0a.stall, m1a.stall);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      n_chk++;
      if (m0a.ack !== 1'b0 || m1a.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_ack%0d: got %b%b want 00", k, m0a.ack, m1a.ack);
      end
    end
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    n_chk++;
    if (gnt_a !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_hold: gnt=%b want 01", gnt_a);
    end
    @(negedge clk); #1;
    n_chk++;
    if (gnt_a !== 2'b10 || sa.stb !== 1'b1 || sa.adr !== 24'h400
        || sa.wdat !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL drain_exit: gnt=%b stb=%b adr=%h dat=%h want 10 1 400 beef",
               gnt_a, sa.stb, sa.adr, sa.wdat);
    end
    mcyc = 2'b00; mstb = 2'b00;
  endtask

  task automatic test_spurious_ack();
    int issued;
    do_reset();
    s_ack = 1'b1; s_rdat = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_chk++;
      if (m0a.ack !== 1'b0 || m1a.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_ack c%0d: got %b%b want 00", c, m0a.ack, m1a.ack);
      end
    end
    s_ack = 1'b0;
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0;
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (sa.stb && !s_stall) issued++;
    end
    n_chk++;
    if (issued != MAX_OUT) begin
      n_fail++;
      $display("FAIL spurious_cnt: accepted %0d want %0d", issued, MAX_OUT);
    end
    mcyc = 2'b00; mstb = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mcyc = 2'b11;
    @(negedge clk);
    mcyc[0] = 1'b0;
    @(negedge clk);
    mstb[1] = 1'b1; mwe[1] = 1'b0; madr[1] = 24'h500;
    #1;
    n_chk++;
    if (gnt_a !== 2'b10 || sa.stb !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: gnt=%b stb=%b want 10/1", gnt_a, sa.stb);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    mstb[1] = 1'b0;
    #1;
    n_chk++;
    if (gnt_a !== 2'b00 || sa.cyc !== 1'b0 || sa.stb !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: gnt=%b cyc=%b stb=%b want 00 0 0",
               gnt_a, sa.cyc, sa.stb);
    end
    @(negedge clk);
    rst = 1'b0;
    mcyc = 2'b11; s_ack = 1'b1;
    #1;
    n_chk++;
    if (gnt_a !== 2'b00 || m0a.ack !== 1'b0 || m1a.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: gnt=%b ack=%b%b want 00 00",
               gnt_a, m0a.ack, m1a.ack);
    end
    @(negedge clk); #1;
    n_chk++;
    if (gnt_a !== 2'b01 || m0a.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_fresh: gnt=%b ack=%b want 01 0", gnt_a, m0a.ack);
    end
    s_ack = 1'b0; mcyc = 2'b00;
  endtask

  task automatic test_random();
    int            left [2], pend [2], wait_c [2], tacc [2], tack [2];
    logic          acc [2], was_acc [2];
    logic          sacc, ah, ao;
    logic [DW-1:0] rd;
    logic [DW-1:0] fq_dat [$];
    int            fq_id [$];
    int            ida, id;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      left[m] = 0; pend[m] = 0; tacc[m] = 0; tack[m] = 0;
      wait_c[m] = $urandom_range(0, 3); was_acc[m] = 1'b0;
    end
    for (int c = 0; c < 1700; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (was_acc[m]) mstb[m] = 1'b0;
        if (mcyc[m] && left[m] == 0 && pend[m] == 0 && !mstb[m]) begin
          mcyc[m] = 1'b0;
          wait_c[m] = $urandom_range(1, 4);
        end else if (!mcyc[m] && c < 1500) begin
          if (wait_c[m] > 0) wait_c[m]--;
          else begin
            mcyc[m] = 1'b1;
            left[m] = $urandom_range(1, 6);
          end
        end
        if (mcyc[m] && !mstb[m] && left[m] > 0 && $urandom_range(0, 3) != 0) begin
          mstb[m] = 1'b1;
          mwe[m] = 1'($urandom);
          madr[m] = AW'($urandom);
          mdat[m] = DW'($urandom);
          msel[m] = SW'($urandom);
        end
      end
      s_stall = ($urandom_range(0, 2) == 0);
      if (fq_id.size() > 0) begin
        s_ack = 1'($urandom);
        s_rdat = fq_dat[0];
      end else begin
        s_ack = ($urandom_range(0, 9) == 0);
        s_rdat = DW'($urandom);
      end
      #1;
      acc[0] = mstb[0] && !m0a.stall;
      acc[1] = mstb[1] && !m1a.stall;
      sacc = sa.stb && !s_stall;
      ida = acc[1] ? 1 : 0;
      n_chk++;
      if (sacc !== (acc[0] || acc[1]) || (acc[0] && acc[1])) begin
        n_fail++;
        $display("FAIL rand_accept c%0d: slave=%b m0=%b m1=%b", c, sacc,
                 acc[0], acc[1]);
      end
      if (acc[0] || acc[1]) begin
        n_chk++;
        if ({sa.we, sa.adr, sa.wdat, sa.sel} !==
            {mwe[ida], madr[ida], mdat[ida], msel[ida]}) begin
          n_fail++;
          $display("FAIL rand_route c%0d: adr=%h want %h (m%0d)", c, sa.adr,
                   madr[ida], ida);
        end
        n_chk++;
        if (fq_id.size() > 0 && fq_id[fq_id.size()-1] != ida) begin
          n_fail++;
          $display("FAIL rand_switch c%0d: m%0d accepted while m%0d outstanding",
                   c, ida, fq_id[fq_id.size()-1]);
        end
      end
      if (s_ack && fq_id.size() > 0) begin
        id = fq_id[0];
        ah = id ? m1a.ack : m0a.ack;
        ao = id ? m0a.ack : m1a.ack;
        rd = id ? m1a.rdat : m0a.rdat;
        n_chk++;
        if (ah !== 1'b1 || ao !== 1'b0 || rd !== fq_dat[0]) begin
          n_fail++;
          $display("FAIL rand_ack c%0d: m%0d ack=%b other=%b dat=%h want 1 0 %h",
                   c, id, ah, ao, rd, fq_dat[0]);
        end
        void'(fq_id.pop_front());
        void'(fq_dat.pop_front());
        pend[id]--;
        tack[id]++;
      end else begin
        n_chk++;
        if (m0a.ack !== 1'b0 || m1a.ack !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_noack c%0d: got %b%b want 00", c, m0a.ack, m1a.ack);
        end
      end
      for (int m = 0; m < 2; m++) was_acc[m] = acc[m];
      if (acc[0] || acc[1]) begin
        fq_id.push_back(ida);
        fq_dat.push_back(DW'($urandom));
        pend[ida]++;
        left[ida]--;
        tacc[ida]++;
        n_chk++;
        if (fq_id.size() > MAX_OUT) begin
          n_fail++;
          $display("FAIL rand_maxout c%0d: outstanding %0d > %0d", c,
                   fq_id.size(), MAX_OUT);
        end
      end
    end
    n_chk++;
    if (fq_id.size() != 0 || mcyc !== 2'b00 || tacc[0] != tack[0]
        || tacc[1] != tack[1] || tacc[0] == 0 || tacc[1] == 0) begin
      n_fail++;
      $display("FAIL rand_end: left=%0d cyc=%b acc=%0d/%0d ack=%0d/%0d",
               fq_id.size(), mcyc, tacc[0], tacc[1], tack[0], tack[1]);
    end
    clear_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_arbitration();
    test_max_out();
    test_drain();
    test_spurious_ack();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
